// File: rtl/alu_seq.sv
// alu_seq: four-state sequencer feeding an external ALU from a 4-entry register file.
// Optional macro CUTE_R0_ZERO_EN turns r0 into a hardwired zero register.
module alu_seq #(
    parameter int WORD_SIZE = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8:0]           in_instr,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [1:0]           ld_addr,
    input  logic [WORD_SIZE-1:0] ld_data,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic                 alu_op,
    input  logic [WORD_SIZE-1:0] alu_c,
    output logic                 done,
    output logic [1:0]           done_rd,
    output logic [WORD_SIZE-1:0] done_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t state;
    state_t state_next;

    logic [WORD_SIZE-1:0] regs [4];
    logic [WORD_SIZE-1:0] result;

    logic       op_q;
    logic [1:0] rd_q;
    logic [1:0] rs1_q;
    logic [1:0] rs2_q;

    logic accept;
    logic ld_accept;

    logic [WORD_SIZE-1:0] rs1_val;
    logic [WORD_SIZE-1:0] rs2_val;

    logic                 wr_en;
    logic [1:0]           wr_addr;
    logic [WORD_SIZE-1:0] wr_data;

    logic unused_bits;

    assign unused_bits = ^in_instr[1:0];
    assign accept      = in_valid && in_ready;
    assign ld_accept   = ld_valid && ld_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; loads win over instructions in IDLE.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        ld_ready   = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy     = 1'b0;
                ld_ready = 1'b1;
                in_ready = !ld_valid;
                if (in_valid && !ld_valid) begin
                    state_next = READ;
                end
            end
            READ: state_next = EXEC;
            EXEC: state_next = WB;
            WB:   state_next = IDLE;
        endcase
    end

    // Register-file read ports, addressed by the latched instruction.
    always_comb begin
        rs1_val = regs[rs1_q];
        rs2_val = regs[rs2_q];
`ifdef CUTE_R0_ZERO_EN
        if (rs1_q == 2'd0) rs1_val = '0;
        if (rs2_q == 2'd0) rs2_val = '0;
`endif
    end

    // Single write port shared by preloads (IDLE only) and write-back (WB only).
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rd_q;
        wr_data = result;
        if (ld_accept) begin
            wr_en   = 1'b1;
            wr_addr = ld_addr;
            wr_data = ld_data;
        end else if (state == WB) begin
            wr_en = 1'b1;
        end
`ifdef CUTE_R0_ZERO_EN
        if (wr_addr == 2'd0) wr_en = 1'b0;
`endif
    end

    // Register file storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Instruction latch, operand issue, result capture and completion report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 1'b0;
            rd_q      <= 2'd0;
            rs1_q     <= 2'd0;
            rs2_q     <= 2'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            done_rd   <= 2'd0;
            done_data <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q  <= in_instr[8];
                rd_q  <= in_instr[7:6];
                rs1_q <= in_instr[5:4];
                rs2_q <= in_instr[3:2];
            end
            if (state == READ) begin
                alu_a  <= rs1_val;
                alu_b  <= rs2_val;
                alu_op <= op_q;
            end
            if (state == EXEC) begin
                result    <= alu_c;
                done      <= 1'b1;
                done_rd   <= rd_q;
                done_data <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a behavioural ALU.
// Honours CUTE_R0_ZERO_EN in its register model.
module tb_alu_seq;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [8:0]   in_instr = '0;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [1:0]   ld_addr = '0;
    logic [W-1:0] ld_data = '0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_op;
    logic [W-1:0] alu_c;
    logic         done;
    logic [1:0]   done_rd;
    logic [W-1:0] done_data;
    logic         busy;

    typedef struct packed {
        logic [1:0]   rd;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb [$];
    logic [W-1:0] m_regs [4];
    int           checks = 0;
    int           fails = 0;

    alu_seq #(.WORD_SIZE(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .done      (done),
        .done_rd   (done_rd),
        .done_data (done_data),
        .busy      (busy)
    );

    assign alu_c = alu_op ? alu_a - alu_b : alu_a + alu_b;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_read(input logic [1:0] i);
`ifdef CUTE_R0_ZERO_EN
        if (i == 2'd0) return '0;
`endif
        return m_regs[i];
    endfunction

    function automatic void m_write(input logic [1:0] i, input logic [W-1:0] v);
`ifdef CUTE_R0_ZERO_EN
        if (i == 2'd0) return;
`endif
        m_regs[i] = v;
    endfunction

    task automatic do_load(input logic [1:0] addr, input logic [W-1:0] data);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_ready: ld_ready=%b required 1", ld_ready);
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        m_write(addr, data);
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [8:0] instr, input bit hold, output int waited);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [1:0]   dst;
        exp_t         e;
        dst      = instr[7:6];
        in_instr = instr;
        in_valid = 1'b1;
        waited   = 0;
        #1;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles required 1", in_ready, waited);
            in_valid = 1'b0;
            return;
        end
        a = m_read(instr[5:4]);
        b = m_read(instr[3:2]);
        r = instr[8] ? a - b : a + b;
        sb.push_back('{rd: dst, data: r});
        m_write(dst, r);
        @(posedge clk);
        #1;
        in_instr = ~instr;
        if (!hold) in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || ld_ready !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL read_cycle: busy=%b done=%b ld_ready=%b in_ready=%b required 1 0 0 0",
                     busy, done, ld_ready, in_ready);
        end
        @(negedge clk);
        checks++;
        if (alu_a !== a) begin
            fails++;
            $display("FAIL alu_a: got %h required %h", alu_a, a);
        end
        checks++;
        if (alu_b !== b) begin
            fails++;
            $display("FAIL alu_b: got %h required %h", alu_b, b);
        end
        checks++;
        if (alu_op !== instr[8]) begin
            fails++;
            $display("FAIL alu_op: got %b required %b", alu_op, instr[8]);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL exec_cycle: busy=%b done=%b required 1 0", busy, done);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL wb_done: done=%b busy=%b required 1 1", done, busy);
        end
        checks++;
        if (done_rd !== e.rd) begin
            fails++;
            $display("FAIL done_rd: got %0d required %0d", done_rd, e.rd);
        end
        checks++;
        if (done_data !== e.data) begin
            fails++;
            $display("FAIL done_data: got %h required %h", done_data, e.data);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_cycle: busy=%b done=%b in_ready=%b ld_ready=%b required 0 0 1 1",
                     busy, done, in_ready, ld_ready);
        end
        checks++;
        if (done_data !== e.data) begin
            fails++;
            $display("FAIL done_data_hold: got %h required %h", done_data, e.data);
        end
    endtask

    task automatic test_reset();
        int w;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || alu_op !== 1'b0 || done_rd !== 2'd0) begin
            fails++;
            $display("FAIL reset_ctrl: done=%b busy=%b alu_op=%b done_rd=%0d required 0 0 0 0",
                     done, busy, alu_op, done_rd);
        end
        checks++;
        if (alu_a !== '0 || alu_b !== '0 || done_data !== '0) begin
            fails++;
            $display("FAIL reset_data: alu_a=%h alu_b=%h done_data=%h required 0 0 0",
                     alu_a, alu_b, done_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: in_ready=%b ld_ready=%b required 1 1", in_ready, ld_ready);
        end
        run_instr(9'h0D8, 1'b0, w);
        checks++;
        if (w !== 0) begin
            fails++;
            $display("FAIL first_accept: waited %0d required 0", w);
        end
    endtask

    task automatic test_add();
        int w;
        do_load(2'd1, 9'd5);
        do_load(2'd2, 9'd3);
        run_instr(9'h0D8, 1'b0, w);
        run_instr(9'h0FC, 1'b0, w);
    endtask

    task automatic test_sub_wrap();
        int w;
        do_load(2'd1, 9'd3);
        do_load(2'd2, 9'd5);
        run_instr(9'h118, 1'b0, w);
        run_instr(9'h040, 1'b0, w);
    endtask

    task automatic test_load_priority();
        int w;
        ld_valid = 1'b1;
        ld_addr  = 2'd2;
        ld_data  = 9'h055;
        in_valid = 1'b1;
        in_instr = 9'h068;
        #1;
        checks++;
        if (in_ready !== 1'b0 || ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL prio_ready: in_ready=%b ld_ready=%b required 0 1", in_ready, ld_ready);
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        m_write(2'd2, 9'h055);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL prio_idle: busy=%b in_ready=%b required 0 1", busy, in_ready);
        end
        run_instr(9'h068, 1'b0, w);
        checks++;
        if (w !== 0) begin
            fails++;
            $display("FAIL prio_next_accept: waited %0d required 0", w);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        do_load(2'd1, 9'h1F0);
        do_load(2'd2, 9'h021);
        run_instr(9'h0E4, 1'b1, w);
        run_instr(9'h19C, 1'b1, w);
        checks++;
        if (w !== 0) begin
            fails++;
            $display("FAIL b2b_spacing1: waited %0d required 0", w);
        end
        run_instr(9'h07C, 1'b0, w);
        checks++;
        if (w !== 0) begin
            fails++;
            $display("FAIL b2b_spacing2: waited %0d required 0", w);
        end
    endtask

    task automatic test_random();
        int w;
        for (int k = 0; k < 6; k++) begin
            do_load(2'($urandom_range(0, 3)), W'($urandom));
            run_instr(9'($urandom), 1'b0, w);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        do_load(2'd1, 9'd9);
        do_load(2'd2, 9'd4);
        in_instr = 9'h0D8;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_op !== 1'b0 || done_rd !== 2'd0) begin
            fails++;
            $display("FAIL midrst_ctrl: busy=%b done=%b alu_op=%b done_rd=%0d required 0 0 0 0",
                     busy, done, alu_op, done_rd);
        end
        checks++;
        if (alu_a !== '0 || alu_b !== '0 || done_data !== '0) begin
            fails++;
            $display("FAIL midrst_data: alu_a=%h alu_b=%h done_data=%h required 0 0 0",
                     alu_a, alu_b, done_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL midrst_no_done: done=%b busy=%b required 0 0", done, busy);
            end
        end
        run_instr(9'h0D8, 1'b0, w);
        do_load(2'd1, 9'd7);
        do_load(2'd2, 9'd2);
        run_instr(9'h118, 1'b0, w);
        run_instr(9'h040, 1'b0, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_wrap();
        test_load_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WORD_SIZE, default 9, data word width shared with the ALU.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ready  output  1  sequencer can accept an instruction this cycle.
REQ-006 in_instr  input  9  instruction: [8] op, [7:6] rd, [5:4] rs1, [3:2] rs2, [1:0] reserved and ignored.
REQ-007 ld_valid  input  1  register preload request.
REQ-008 ld_ready  output  1  preload accepted this cycle.
REQ-009 ld_addr  input  2  preload target register.
REQ-010 ld_data  input  WORD_SIZE  preload value.
REQ-011 alu_a  output  WORD_SIZE  first operand to the ALU, registered.
REQ-012 alu_b  output  WORD_SIZE  second operand to the ALU, registered.
REQ-013 alu_op  output  1  ALU select: 0 = a+b, 1 = a-b, registered.
REQ-014 alu_c  input  WORD_SIZE  combinational ALU result.
REQ-015 done  output  1  one-cycle pulse at write-back.
REQ-016 done_rd  output  2  destination register of the completing instruction.
REQ-017 done_data  output  WORD_SIZE  value written at completion.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 Register file: four WORD_SIZE-bit registers r0..r3, internal to the block.
REQ-020 FSM states: IDLE, READ, EXEC, WB.
- IDLE->READ on in_valid&&in_ready.
- READ->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-021 On accept, the instruction is latched; in_instr is don't-care afterwards.
REQ-022 READ: alu_a<=r[rs1], alu_b<=r[rs2], alu_op<=op; these hold until the next READ.
REQ-023 EXEC: alu_c is captured into an internal result register.
REQ-024 WB:
- r[rd]<=result.
- done=1; done_rd and done_data valid for this cycle only.
- done_data stays at its last value otherwise.
REQ-025 Timing:
- Accept at edge N gives done high in cycle N+3 and r[rd] updated at edge N+3.
- Earliest next accept is N+4; throughput is one instruction per 4 cycles.
REQ-026 Arithmetic wraps modulo 2^WORD_SIZE as produced by the ALU; the sequencer never alters alu_c.
REQ-027 rs1/rs2 equal to rd of the immediately preceding instruction read the written-back value; no hazard is possible.
REQ-028 ld_ready = (state==IDLE); an accepted load writes r[ld_addr]<=ld_data at that edge.
REQ-029 in_ready = (state==IDLE) && !ld_valid, so a load has priority over an instruction in the same cycle.
REQ-030 ld_valid outside IDLE is ignored (ld_ready=0); the requester holds it.

Reset
REQ-031 rst asserted:
- FSM to IDLE.
- r0..r3, alu_a, alu_b, alu_op, done_data and done_rd to 0.
- done=0 and busy=0.
REQ-032 Reset mid-instruction aborts it: no write-back, no done pulse.
REQ-033 First accept is possible on the first edge after rst deasserts.

Configuration
REQ-034 Macro CUTE_R0_ZERO_EN defined:
- r0 reads as 0.
- Preloads and write-backs to r0 are discarded.
- done still pulses, with done_rd=0 and done_data=ALU result.
REQ-035 CUTE_R0_ZERO_EN undefined: r0 is an ordinary register.

Verification (WORD_SIZE=9)
REQ-036 Load r1=5, r2=3; instr 0x0D8 (add r3=r1+r2) accepted at N -> alu_a=5, alu_b=3, alu_op=0 after READ; done at N+3 with done_rd=3, done_data=8; r3=8.
REQ-037 r1=3, r2=5; instr 0x118 (sub r0=r1-r2) -> done_data=0x1FE (wrap).
- Macro undefined: r0=0x1FE.
- Macro defined: r0 stays 0.
REQ-038 in_valid and ld_valid high together in IDLE -> load written, in_ready=0; instruction accepted the next cycle.
REQ-039 in_valid held high continuously -> accepts 4 cycles apart; busy low only in accept cycles.
REQ-040 rst pulsed in EXEC -> no done, all registers 0, busy=0; subsequent instruction completes normally.
